program_loader: RTL

Writable 16x8 program store that feeds the TD4 core's instruction port. It replaces the fixed ROM on the A/D bus and accepts a program through a byte-stream valid/ready handshake. While a load is in progress it holds the core in reset. Once loaded, it releases the core so execution starts from address 0 with the new program.

---
 rtl/td4_pkg.sv | 28 ++
 rtl/program_loader_if.sv | 33 +++
 rtl/program_loader_mem.sv | 38 +++
 rtl/program_loader.sv | 128 ++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared constants for the TD4 program loader
//
// Purpose : loader FSM state encoding, default bus widths and the TD4
//           opcodes used when building test programs.
// Ports   : none (package).

package td4_pkg;

    // Default geometry of the program store.
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    // Loader FSM state encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_FILL    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // TD4 opcodes (upper nibble of an instruction word).
    localparam logic [3:0] OP_OUT_IM = 4'b1011;
    localparam logic [3:0] OP_JMP_IM = 4'b1111;

    // Build an 8-bit TD4 instruction from opcode and immediate.
    function automatic logic [7:0] mk_insn(input logic [3:0] op, input logic [3:0] im);
        return {op, im};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - host-side byte-stream load interface
//
// Purpose : groups the program-load handshake and status signals.
// Signals : LD_START  host -> loader  request a load session
//           LD_VALID  host -> loader  LD_DATA holds a byte
//           LD_DATA   host -> loader  program byte
//           LD_END    host -> loader  no more bytes
//           LD_READY  loader -> host  byte accepted this cycle
//           LD_DONE   loader -> host  pulse on first run cycle after load
//           BUSY      loader -> host  load, fill or release in progress
// Modports: master (host side), slave (loader side).

interface program_loader_if #(
    parameter int DATA_W = 8
);
    logic              LD_START;
    logic              LD_VALID;
    logic [DATA_W-1:0] LD_DATA;
    logic              LD_END;
    logic              LD_READY;
    logic              LD_DONE;
    logic              BUSY;

    modport master (
        output LD_START, LD_VALID, LD_DATA, LD_END,
        input  LD_READY, LD_DONE, BUSY
    );

    modport slave (
        input  LD_START, LD_VALID, LD_DATA, LD_END,
        output LD_READY, LD_DONE, BUSY
    );
endinterface

// File: rtl/program_loader_mem.sv
// rtl/program_loader_mem.sv - program store register array
//
// Purpose : 2**ADDR_W x DATA_W register array, cleared asynchronously,
//           one synchronous write port and one combinational read port.
// Ports   : clk, rst_n           clock, async active-low clear
//           we, waddr, wdata     write port (rising edge)
//           raddr, rdata         combinational read port

module loader_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero-latency read: the core fetches straight from the array.
    assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - writable TD4 program store with load FSM
//
// Purpose : replaces the TD4 ROM; accepts a program over a byte stream,
//           holds the core in reset while loading, zero-fills the unused
//           tail and then releases the core to run from address 0.
// Ports   : CLK      system clock
//           CLR      asynchronous active-low reset
//           A        instruction address from the core
//           D        instruction word to the core (combinational)
//           CPU_CLR  registered active-low reset for the core
//           ld       load handshake interface (slave side)

module program_loader
    import td4_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic              CPU_CLR,
    program_loader_if.slave   ld
);
    localparam int DEPTH = 1 << ADDR_W;
    // ptr carries one extra bit so "all words written" is ptr == DEPTH
    // rather than a wrap back to 0.
    localparam logic [ADDR_W:0] PTR_END = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W:0]   ptr_after;
    logic              cpu_clr;
    logic              ld_done;

    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    // Write-port control: host bytes in LOAD, zeros in FILL. The top-bit
    // guard keeps a stray write from ever landing on an aliased address.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            ST_LOAD: begin
                if (ld.LD_VALID && !ptr[ADDR_W]) begin
                    mem_we    = 1'b1;
                    mem_wdata = ld.LD_DATA;
                end
            end
            ST_FILL: begin
                mem_we = !ptr[ADDR_W];
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Pointer value after this cycle's write; END decisions use this so a
    // byte offered together with END is counted before END is applied.
    assign ptr_after = mem_we ? ptr + (ADDR_W + 1)'(1) : ptr;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cpu_clr <= 1'b0;
            ld_done <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cpu_clr <= 1'b1;
                    if (ld.LD_START) begin
                        state   <= ST_LOAD;
                        ptr     <= '0;
                        cpu_clr <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    ptr <= ptr_after;
                    if (ptr_after == PTR_END) begin
                        state <= ST_RELEASE;
                    end else if (ld.LD_END) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    ptr <= ptr_after;
                    if (ptr_after == PTR_END) begin
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Core leaves reset on the same edge LD_DONE rises,
                    // so the pulse marks its first running cycle.
                    state   <= ST_IDLE;
                    cpu_clr <= 1'b1;
                    ld_done <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    loader_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (CLK),
        .rst_n (CLR),
        .we    (mem_we),
        .waddr (ptr[ADDR_W-1:0]),
        .wdata (mem_wdata),
        .raddr (A),
        .rdata (D)
    );

    assign CPU_CLR     = cpu_clr;
    assign ld.LD_READY = (state == ST_LOAD);
    assign ld.BUSY     = (state != ST_IDLE);
    assign ld.LD_DONE  = ld_done;

endmodule
